// File: rtl/divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, with a
// start/busy/valid handshake for the calculator control FSM.
module divider #(
  parameter int unsigned inSize = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [inSize-1:0] A,
  input  logic [inSize-1:0] B,
  output logic [inSize-1:0] quotient,
  output logic [inSize-1:0] remainder,
  output logic              valid,
  output logic              busy,
  output logic              div_by_zero
);

  localparam int unsigned CW = $clog2(inSize + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t              r_state;
  // Dividend bits shift out at the top while quotient bits shift in at the
  // bottom, so after inSize steps this register holds the quotient.
  logic [inSize-1:0]   r_dividend;
  logic [inSize-1:0]   r_divisor;
  // Partial remainder is always < divisor after each step, so inSize bits
  // suffice to hold it; the extra bit only exists in the shifted trial value.
  logic [inSize-1:0]   r_rem;
  logic [CW-1:0]       r_count;

  logic [inSize:0]     w_rshift;
  logic                w_ge;
  logic [inSize-1:0]   w_rem_next;
  logic [inSize-1:0]   w_dividend_next;

  // One restoring step: shift in next dividend bit, trial-subtract divisor.
  always_comb begin
    w_rshift        = {r_rem, r_dividend[inSize-1]};
    w_ge            = (w_rshift >= {1'b0, r_divisor});
    w_rem_next      = w_ge ? inSize'(w_rshift - {1'b0, r_divisor})
                           : w_rshift[inSize-1:0];
    w_dividend_next = {r_dividend[inSize-2:0], w_ge};
  end

  // Control FSM, datapath registers and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_rem       <= '0;
      r_count     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      valid       <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          valid <= 1'b0;
          if (en) begin
            r_dividend <= A;
            r_divisor  <= B;
            r_rem      <= '0;
            r_count    <= CW'(inSize);
            busy       <= 1'b1;
            if (B == '0) begin
              // Zero divisor skips the iteration and reports a saturated result.
              r_state     <= S_DONE;
              quotient    <= '1;
              remainder   <= A;
              div_by_zero <= 1'b1;
              valid       <= 1'b1;
            end else begin
              r_state <= S_DIVIDE;
            end
          end
        end
        S_DIVIDE: begin
          r_dividend <= w_dividend_next;
          r_rem      <= w_rem_next;
          r_count    <= r_count - CW'(1);
          if (r_count == CW'(1)) begin
            r_state     <= S_DONE;
            quotient    <= w_dividend_next;
            remainder   <= w_rem_next;
            div_by_zero <= 1'b0;
            valid       <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          valid   <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          valid   <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
